reg_scan_display: RTL and testbench

- Board-level consumer of the single-cycle computer's register-debug port.
- Drives reg_sel and samples the returned reg_data word into a shadow register.
- Shows the word as 8 hex digits on a time-multiplexed 8-digit 7-segment display.
- Two modes: auto mode steps through r0..r31 at a fixed frame rate; manual mode shows the register chosen on board switches.

---
 rtl/reg_scan_pkg.sv | 10 +
 rtl/hex_to_seg.sv | 10 +
 rtl/reg_scan_display.sv | 72 +++++++
 tb/tb_reg_scan_display.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/reg_scan_pkg.sv
// reg_scan_pkg: shared constants for the register-scan 7-segment display.
package reg_scan_pkg;
  localparam int NDIGITS = 8;
  localparam int NREGS = 32;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [6:0] SEG_HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
endpackage

// File: rtl/hex_to_seg.sv
// hex_to_seg: nibble to active-low {dp,g..a} segments, dp off, optional blanking.
module hex_to_seg
  import reg_scan_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       blank,
  output logic [7:0] seg
);
  assign seg = blank ? SEG_BLANK : {1'b1, SEG_HEX[nib]};
endmodule

// File: rtl/reg_scan_display.sv
// reg_scan_display: scans the register-debug port onto an 8-digit multiplexed hex display.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module reg_scan_display
  import reg_scan_pkg::*;
#(
  parameter int DIGIT_DIV      = 50000,
  parameter int FRAMES_PER_REG = 250
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        auto_mode,
  input  logic [4:0]  manual_sel,
  input  logic [31:0] reg_data,
  output logic [4:0]  reg_sel,
  output logic [7:0]  an,
  output logic [7:0]  seg
);
  localparam int CW = $clog2(DIGIT_DIV);
  localparam int FW = FRAMES_PER_REG > 1 ? $clog2(FRAMES_PER_REG) : 1;
  localparam int DW = $clog2(NDIGITS);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] digit_q, digit_d;
  logic [FW-1:0] frame_q, frame_d;
  logic [4:0]    scan_q, scan_d, reg_sel_q, reg_sel_d;
  logic [31:0]   shadow_q, shadow_d;
  logic [7:0]    an_q, an_d, seg_q, seg_d, seg_dec;
  logic          tick, boundary, advance, blank;
  // digit_q is the digit being put up on this tick; it advances on the same edge
  hex_to_seg u_hex (.nib(shadow_q[{digit_q, 2'b00} +: 4]), .blank(blank), .seg(seg_dec));
`ifdef LEADING_ZERO_BLANK_EN
  assign blank = (digit_q != '0) && ((shadow_q >> {digit_q, 2'b00}) == 32'h0);
`else
  assign blank = 1'b0;
`endif
  always_comb begin
    tick      = cnt_q == CW'(DIGIT_DIV - 1);
    boundary  = tick && (digit_q == DW'(NDIGITS - 1));
    advance   = boundary && auto_mode && (frame_q == FW'(FRAMES_PER_REG - 1));
    cnt_d     = tick ? '0 : cnt_q + 1'b1;
    digit_d   = tick ? digit_q + 1'b1 : digit_q;
    frame_d   = !(boundary && auto_mode) ? frame_q : advance ? '0 : frame_q + 1'b1;
    scan_d    = advance ? scan_q + 5'd1 : scan_q;
    reg_sel_d = auto_mode ? scan_q : manual_sel;
    shadow_d  = boundary ? reg_data : shadow_q;
    an_d      = tick ? ~(8'b1 << digit_q) : an_q;
    seg_d     = tick ? seg_dec : seg_q;
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q     <= '0;
      digit_q   <= '0;
      frame_q   <= '0;
      scan_q    <= '0;
      reg_sel_q <= '0;
      shadow_q  <= '0;
      an_q      <= SEG_BLANK;
      seg_q     <= SEG_BLANK;
    end else begin
      cnt_q     <= cnt_d;
      digit_q   <= digit_d;
      frame_q   <= frame_d;
      scan_q    <= scan_d;
      reg_sel_q <= reg_sel_d;
      shadow_q  <= shadow_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end
  assign reg_sel = reg_sel_q;
  assign an      = an_q;
  assign seg     = seg_q;
endmodule

// File: tb/tb_reg_scan_display.sv
// tb_reg_scan_display: table vectors, corner sequences and a randomized run against a cycle-count model.
module tb_reg_scan_display;
  localparam int DIV = 4;
  localparam int FPR = 2;
  localparam logic [6:0] HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [7:0] LZ = 8'hFF;
`else
  localparam logic [7:0] LZ = 8'hC0;
`endif
  typedef struct {
    logic [31:0] data;
    logic [7:0]  an;
    logic [7:0]  seg;
  } vec_t;
  logic        clk, rstn, auto_mode, use_mem;
  logic [4:0]  manual_sel, reg_sel;
  logic [31:0] reg_data, data_ovr;
  logic [31:0] mem [32];
  logic [7:0]  an, seg;
  int pass_cnt = 0, total_cnt = 0;
  int m_cyc, m_scan, m_frames;
  logic [4:0]  m_sel;
  logic [31:0] m_shadow;
  logic [7:0]  m_an, m_seg;
  vec_t tv [16];

  reg_scan_display #(.DIGIT_DIV(DIV), .FRAMES_PER_REG(FPR)) dut (
    .clk(clk), .rstn(rstn), .auto_mode(auto_mode), .manual_sel(manual_sel),
    .reg_data(reg_data), .reg_sel(reg_sel), .an(an), .seg(seg)
  );
  assign reg_data = use_mem ? mem[reg_sel] : data_ovr;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] exp_seg(logic [31:0] w, int d);
`ifdef LEADING_ZERO_BLANK_EN
    if (d > 0 && (w >> (4 * d)) == 32'h0) return 8'hFF;
`endif
    return {1'b1, HEX[w[4*d +: 4]]};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // One clock: the model sees the inputs stable before the edge, then outputs are compared mid-cycle.
  task automatic step();
    logic a, r;
    logic [4:0] ms, nsel;
    logic [31:0] rd;
    int d;
    a = auto_mode; ms = manual_sel; rd = reg_data; r = rstn;
    @(posedge clk);
    if (!r) begin
      m_cyc = 0; m_scan = 0; m_frames = 0; m_sel = 0; m_shadow = 0;
      m_an = 8'hFF; m_seg = 8'hFF;
    end else begin
      nsel = a ? 5'(m_scan) : ms;
      m_cyc++;
      if (m_cyc % DIV == 0) begin
        d = ((m_cyc / DIV) - 1) % 8;
        m_an = ~(8'b1 << d);
        m_seg = exp_seg(m_shadow, d);
        if (d == 7) begin
          m_shadow = rd;
          if (a) begin
            m_frames++;
            if (m_frames % FPR == 0) m_scan = (m_scan + 1) % 32;
          end
        end
      end
      m_sel = nsel;
    end
    @(negedge clk);
    chk("model_an", an, m_an);
    chk("model_seg", seg, m_seg);
    chk("model_reg_sel", reg_sel, m_sel);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (3) step();
    rstn = 1'b1;
  endtask

  initial begin
    int found;
    rstn = 1'b0; auto_mode = 1'b1; manual_sel = 5'd3; use_mem = 1'b1; data_ovr = 32'h0;
    for (int i = 0; i < 32; i++) mem[i] = 32'(i);
    tv[0]  = '{32'h1234ABCD, 8'hFE, 8'hA1};
    tv[1]  = '{32'h1234ABCD, 8'hFD, 8'hC6};
    tv[2]  = '{32'h1234ABCD, 8'hFB, 8'h83};
    tv[3]  = '{32'h1234ABCD, 8'hF7, 8'h88};
    tv[4]  = '{32'h1234ABCD, 8'hEF, 8'h99};
    tv[5]  = '{32'h1234ABCD, 8'hDF, 8'hB0};
    tv[6]  = '{32'h1234ABCD, 8'hBF, 8'hA4};
    tv[7]  = '{32'h1234ABCD, 8'h7F, 8'hF9};
    tv[8]  = '{32'h000000A0, 8'hFE, 8'hC0};
    tv[9]  = '{32'h000000A0, 8'hFD, 8'h88};
    tv[10] = '{32'h000000A0, 8'hFB, LZ};
    tv[11] = '{32'h000000A0, 8'hF7, LZ};
    tv[12] = '{32'h000000A0, 8'hEF, LZ};
    tv[13] = '{32'h000000A0, 8'hDF, LZ};
    tv[14] = '{32'h000000A0, 8'hBF, LZ};
    tv[15] = '{32'h000000A0, 8'h7F, LZ};

    // reset state and first tick
    repeat (3) step();
    chk("rst_an", an, 8'hFF);
    chk("rst_seg", seg, 8'hFF);
    chk("rst_reg_sel", reg_sel, 5'd0);
    rstn = 1'b1;
    repeat (3) step();
    chk("pre_tick_an", an, 8'hFF);
    step();
    chk("first_tick_an", an, 8'hFE);

    // scan order and decode table, manual mode
    auto_mode = 1'b0; use_mem = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i % 8 == 0) begin
        data_ovr = tv[i].data;
        do_reset();
        repeat (32) step();
      end
      repeat (4) step();
      chk($sformatf("tv%0d_an", i), an, tv[i].an);
      chk($sformatf("tv%0d_seg", i), seg, tv[i].seg);
    end

    // tear-free latch: mid-frame data change stays hidden until the boundary
    data_ovr = 32'h1234ABCD;
    do_reset();
    repeat (40) step();
    data_ovr = 32'h55555555;
    repeat (24) step();
    chk("tear_old_digit7", seg, 8'hF9);
    repeat (4) step();
    chk("tear_new_digit0", seg, 8'h92);

    // reset mid-frame at digit 5
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      step();
      if (an == 8'hDF) found = 1;
    end
    chk("reach_digit5", 32'(found), 32'd1);
    chk("reg_sel_manual", reg_sel, 5'd3);
    rstn = 1'b0;
    step();
    chk("midrst_an", an, 8'hFF);
    chk("midrst_reg_sel", reg_sel, 5'd0);
    rstn = 1'b1;
    repeat (4) step();
    chk("midrst_restart_an", an, 8'hFE);

    // auto advance with reg_data = {27'h0, reg_sel}
    auto_mode = 1'b1; use_mem = 1'b1;
    do_reset();
    repeat (64) step();
    chk("auto_sel_before", reg_sel, 5'd0);
    step();
    chk("auto_sel_after", reg_sel, 5'd1);
    repeat (3) step();
    chk("auto_shadow_old", seg, 8'hC0);
    repeat (32) step();
    chk("auto_shadow_new", seg, 8'hF9);
    repeat (1948) step();
    chk("auto_sel_31", reg_sel, 5'd31);
    step();
    chk("auto_wrap_0", reg_sel, 5'd0);

    // randomized run against the model
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(199) == 0) auto_mode = ~auto_mode;
      if ($urandom_range(49) == 0) manual_sel = 5'($urandom);
      if ($urandom_range(19) == 0) mem[$urandom_range(31)] = $urandom;
      rstn = $urandom_range(1499) != 0;
      step();
    end
    rstn = 1'b1;
    step();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
